icon_colorizer: RTL

Video output stage directly downstream of the icon pixel mapper. Each clock it merges the 2-bit icon code from the mapper with the 2-bit world-map code into a registered 12-bit RGB pixel. It delays the display timing generator's sync and blanking signals so they stay aligned with the icon path's pipeline latency. It also counts frames and emits a per-frame tick; an optional build feature uses that count to blink the rojobot icon.

---
 rtl/icon_colorizer_if.sv | 25 ++
 rtl/icon_colorizer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/icon_colorizer_if.sv
// Pixel/timing bundle between the display timing path and icon_colorizer.
// master = upstream source plus display sink, slave = the colorizer.
interface icon_colorizer_if;
  logic       video_on;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] world_pixel;
  logic [1:0] icon;
  logic [3:0] vga_red;
  logic [3:0] vga_green;
  logic [3:0] vga_blue;
  logic       hsync_out;
  logic       vsync_out;
  logic       frame_tick;

  modport master (
    output video_on, hsync_in, vsync_in, world_pixel, icon,
    input  vga_red, vga_green, vga_blue, hsync_out, vsync_out, frame_tick
  );

  modport slave (
    input  video_on, hsync_in, vsync_in, world_pixel, icon,
    output vga_red, vga_green, vga_blue, hsync_out, vsync_out, frame_tick
  );
endinterface

// File: rtl/icon_colorizer.sv
// Merges icon and world-map codes into registered 12-bit RGB, realigns sync/blank,
// and counts frames. Define ICON_COLORIZER_BLINK_EN to blink the icon every BLINK_FRAMES frames.
module icon_colorizer #(
  parameter int SYNC_DLY     = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset_n,
  icon_colorizer_if.slave  bus
);

  localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

  function automatic logic [11:0] icon_rgb(input logic [1:0] code);
    case (code)
      2'd1:    icon_rgb = 12'h0F0;
      2'd2:    icon_rgb = 12'hFF0;
      2'd3:    icon_rgb = 12'hF0F;
      default: icon_rgb = 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] world_rgb(input logic [1:0] code);
    case (code)
      2'd0:    world_rgb = 12'hFFF;
      2'd1:    world_rgb = 12'h000;
      2'd2:    world_rgb = 12'hF00;
      default: world_rgb = 12'h00F;
    endcase
  endfunction

  logic [SYNC_DLY-1:0] r_vid_dly;
  logic [SYNC_DLY-1:0] r_hs_dly;
  logic [SYNC_DLY-1:0] r_vs_dly;
  logic                w_vid_d;
  logic                w_hs_d;
  logic                w_vs_d;
  logic                w_icon_hide;
  logic [11:0]         w_rgb;
  logic [11:0]         r_rgb;
  logic                r_hsync;
  logic                r_vsync;
  logic                r_frame_tick;
  logic [7:0]          r_frame_cnt;

  // Stage p0..p(SYNC_DLY-1): timing delay line matching the icon mapper latency
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vid_dly <= '0;
      r_hs_dly  <= '1;
      r_vs_dly  <= '1;
    end else begin
      r_vid_dly[0] <= bus.video_on;
      r_hs_dly[0]  <= bus.hsync_in;
      r_vs_dly[0]  <= bus.vsync_in;
      for (int k = 1; k < SYNC_DLY; k++) begin
        r_vid_dly[k] <= r_vid_dly[k-1];
        r_hs_dly[k]  <= r_hs_dly[k-1];
        r_vs_dly[k]  <= r_vs_dly[k-1];
      end
    end
  end

  assign w_vid_d = r_vid_dly[SYNC_DLY-1];
  assign w_hs_d  = r_hs_dly[SYNC_DLY-1];
  assign w_vs_d  = r_vs_dly[SYNC_DLY-1];

`ifdef ICON_COLORIZER_BLINK_EN
  logic r_blink_phase;
  assign w_icon_hide = r_blink_phase;
`else
  assign w_icon_hide = 1'b0;
`endif

  always_comb begin
    w_rgb = 12'h000;
    if (!w_vid_d)
      w_rgb = 12'h000;
    else if (bus.icon != 2'd0 && !w_icon_hide)
      w_rgb = icon_rgb(bus.icon);
    else
      w_rgb = world_rgb(bus.world_pixel);
  end

  // Output stage: RGB, syncs and frame tick share one register boundary.
  // r_vsync doubles as the previous-vsync register for edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rgb        <= 12'h000;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_rgb        <= w_rgb;
      r_hsync      <= w_hs_d;
      r_vsync      <= w_vs_d;
      r_frame_tick <= r_vsync & ~w_vs_d;
    end
  end

  // Frame counter stage: advances on the registered tick, so wraps land one cycle later
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_frame_cnt <= 8'd0;
`ifdef ICON_COLORIZER_BLINK_EN
      r_blink_phase <= 1'b0;
`endif
    end else if (r_frame_tick) begin
      if (r_frame_cnt >= LAST_FRAME) begin
        r_frame_cnt <= 8'd0;
`ifdef ICON_COLORIZER_BLINK_EN
        r_blink_phase <= ~r_blink_phase;
`endif
      end else begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign bus.vga_red    = r_rgb[11:8];
  assign bus.vga_green  = r_rgb[7:4];
  assign bus.vga_blue   = r_rgb[3:0];
  assign bus.hsync_out  = r_hsync;
  assign bus.vsync_out  = r_vsync;
  assign bus.frame_tick = r_frame_tick;

endmodule
